// File: rtl/mas_rr_arbiter.sv
// mas_rr_arbiter: round-robin arbiter with burst lock and a registered single-entry output stage
module mas_rr_arbiter #(
    parameter int N_INPUTS   = 8,
    parameter int DATA_WIDTH = 128,
    parameter int MAX_BURST  = 4,
    parameter int IDX_W      = $clog2(N_INPUTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_INPUTS-1:0]            req,
    input  logic [N_INPUTS-1:0]            lock,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] data_in,
    output logic [N_INPUTS-1:0]            grant,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic [IDX_W-1:0]               out_src,
    output logic                           contended,
    output logic                           active
);
    logic [IDX_W-1:0]      r_ptr;
    logic [7:0]            r_burst;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [IDX_W-1:0]      r_src;
    logic                  r_cont;
    logic                  w_load;
    logic                  w_hit;
    logic                  w_fire;
    logic                  w_lock;
    logic [IDX_W-1:0]      w_win;
    logic [IDX_W-1:0]      w_next;
    logic [DATA_WIDTH-1:0] w_data;

    function automatic int wrap(input int a);
        return (a >= N_INPUTS) ? a - N_INPUTS : a;
    endfunction

    // rotating priority search: the lowest offset from r_ptr with req set wins
    always_comb begin
        w_hit  = 1'b0;
        w_win  = '0;
        w_data = '0;
        for (int i = N_INPUTS - 1; i >= 0; i--) begin
            if (req[wrap(int'(r_ptr) + i)]) begin
                w_hit  = 1'b1;
                w_win  = IDX_W'(wrap(int'(r_ptr) + i));
                w_data = data_in[wrap(int'(r_ptr) + i) * DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_load    = !r_valid || out_ready;
    assign w_fire    = w_load && w_hit && !rst;
    assign grant     = w_fire ? (N_INPUTS'(1) << w_win) : '0;
    assign w_lock    = lock[w_win] && (int'(r_burst) < MAX_BURST - 1);
    assign w_next    = (int'(w_win) == N_INPUTS - 1) ? '0 : w_win + 1'b1;
    assign out_valid = r_valid;
    assign data_out  = r_data;
    assign out_src   = r_src;
    assign contended = r_cont;
    assign active    = |req;

    // output stage and arbitration state; everything holds while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
            r_cont  <= 1'b0;
            r_ptr   <= '0;
            r_burst <= '0;
        end else if (w_load) begin
            r_valid <= w_hit;
            if (w_hit) begin
                r_data  <= w_data;
                r_src   <= w_win;
                r_cont  <= $countones(req) > 1;
                r_ptr   <= w_lock ? w_win : w_next;
                r_burst <= w_lock ? r_burst + 8'd1 : '0;
            end
        end
    end
endmodule

// File: tb/tb_mas_rr_arbiter.sv
// tb_mas_rr_arbiter: table-driven check of mas_rr_arbiter with N_INPUTS=4, DATA_WIDTH=8, MAX_BURST=3
module tb_mas_rr_arbiter;
    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic       rdy;
        logic [3:0] g;
        logic       v;
        logic [7:0] d;
        logic [1:0] s;
        logic       c;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'hF;
    logic [3:0]  lock = 4'h0;
    logic [31:0] data_in = 32'h13121110;
    logic [3:0]  grant;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  data_out;
    logic [1:0]  out_src;
    logic        contended;
    logic        active;
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        tv[$];

    mas_rr_arbiter #(.N_INPUTS(4), .DATA_WIDTH(8), .MAX_BURST(3)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .data_in(data_in),
        .grant(grant), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .out_src(out_src), .contended(contended), .active(active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] g, input logic v,
                            input logic [7:0] d, input logic [1:0] s, input logic c);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"}, 32'(data_out), 32'(d));
        chk({tag, ".src"}, 32'(out_src), 32'(s));
        chk({tag, ".cont"}, 32'(contended), 32'(c));
        chk({tag, ".active"}, 32'(active), 32'(|req));
    endtask

    initial begin
        // all four requesting: 0,1,2,3 then wrap to 0
        tv.push_back('{4'hF, 4'h0, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0});
        tv.push_back('{4'hF, 4'h0, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0, 1'b1});
        tv.push_back('{4'hF, 4'h0, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd1, 1'b1});
        tv.push_back('{4'hF, 4'h0, 1'b1, 4'b1000, 1'b1, 8'h12, 2'd2, 1'b1});
        tv.push_back('{4'hF, 4'h0, 1'b1, 4'b0001, 1'b1, 8'h13, 2'd3, 1'b1});
        // single requester, then idle drops out_valid but holds payload
        tv.push_back('{4'h4, 4'h0, 1'b1, 4'b0100, 1'b1, 8'h10, 2'd0, 1'b1});
        tv.push_back('{4'h0, 4'h0, 1'b1, 4'b0000, 1'b1, 8'h12, 2'd2, 1'b0});
        tv.push_back('{4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 8'h12, 2'd2, 1'b0});
        // backpressure for three cycles, then resume from saved pointer
        tv.push_back('{4'hF, 4'h0, 1'b1, 4'b1000, 1'b0, 8'h12, 2'd2, 1'b0});
        tv.push_back('{4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 8'h13, 2'd3, 1'b1});
        tv.push_back('{4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 8'h13, 2'd3, 1'b1});
        tv.push_back('{4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 8'h13, 2'd3, 1'b1});
        tv.push_back('{4'hF, 4'h0, 1'b1, 4'b0001, 1'b1, 8'h13, 2'd3, 1'b1});
        // move pointer to 2, then locked burst on channel 0 capped at 3
        tv.push_back('{4'h2, 4'h0, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0, 1'b1});
        tv.push_back('{4'h3, 4'h1, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd1, 1'b0});
        tv.push_back('{4'h3, 4'h1, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1});
        tv.push_back('{4'h3, 4'h1, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1});
        tv.push_back('{4'h3, 4'h1, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0, 1'b1});
        tv.push_back('{4'h3, 4'h1, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd1, 1'b1});
        tv.push_back('{4'h3, 4'h1, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1});
        tv.push_back('{4'h3, 4'h1, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1});
        tv.push_back('{4'h3, 4'h1, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0, 1'b1});
        // lock granted twice, requester drops, burst count must restart
        tv.push_back('{4'h3, 4'h1, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd1, 1'b1});
        tv.push_back('{4'h3, 4'h1, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1});
        tv.push_back('{4'h2, 4'h0, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0, 1'b1});
        tv.push_back('{4'h3, 4'h1, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd1, 1'b0});
        tv.push_back('{4'h3, 4'h1, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1});
        tv.push_back('{4'h3, 4'h1, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1});
        tv.push_back('{4'h3, 4'h1, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0, 1'b1});

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outs("in_reset", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (tv[i]) begin
            req       = tv[i].req;
            lock      = tv[i].lock;
            out_ready = tv[i].rdy;
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), tv[i].g, tv[i].v, tv[i].d, tv[i].s, tv[i].c);
            @(posedge clk);
            #1;
        end

        // reset while stalled with pointer at 2 discards payload and restarts search at 0
        req       = 4'hF;
        lock      = 4'h0;
        out_ready = 1'b0;
        @(negedge clk);
        chk_outs("stall", 4'b0000, 1'b1, 8'h11, 2'd1, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_pulse.grant", 32'(grant), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_outs("after_rst", 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_outs("after_rst_load", 4'b0000, 1'b1, 8'h10, 2'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mas_rr_arbiter.md
MAS_RR_ARBITER -- requirements
Module: mas_rr_arbiter

Interface
REQ-001 The block SHALL have parameter N_INPUTS, default 8: number of requesting channels, legal range 2..32.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 128: width of each request payload.
REQ-003 The block SHALL have parameter MAX_BURST, default 4: maximum consecutive grants to one locked channel, legal range 1..255.
REQ-004 The block SHALL have parameter IDX_W, default $clog2(N_INPUTS): width of the channel index.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port req, input, N_INPUTS bits: per-channel request.
REQ-008 The block SHALL have port lock, input, N_INPUTS bits: per-channel burst-lock request, meaningful only with req.
REQ-009 The block SHALL have port data_in, input, N_INPUTS*DATA_WIDTH bits: channel k payload at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 The block SHALL have port grant, output, N_INPUTS bits: one-hot or zero; combinational; channel consumed at the edge where its bit is high.
REQ-011 The block SHALL have port out_valid, output, 1 bit: data_out holds a serviced payload.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts data_out this cycle.
REQ-013 The block SHALL have port data_out, output, DATA_WIDTH bits: registered serviced payload.
REQ-014 The block SHALL have port out_src, output, IDX_W bits: registered index of the channel that supplied data_out.
REQ-015 The block SHALL have port contended, output, 1 bit: registered; 1 if more than one req bit was high at the grant that loaded data_out.
REQ-016 The block SHALL have port active, output, 1 bit: combinational OR of req.

Function
REQ-017 load = !out_valid || out_ready; grant SHALL be all-zero whenever load=0 or req=0.
REQ-018 When load=1 and req!=0, winner SHALL be the first channel with req set, searching rr_ptr, rr_ptr+1, ... wrapping at N_INPUTS-1 to 0; grant[winner]=1 only.
REQ-019 On a granted edge: data_out<=data_in[winner], out_src<=winner, contended<=(popcount(req)>1), out_valid<=1; latency from grant to out_valid is exactly 1 cycle.
REQ-020 On load=1 with no grant: out_valid<=0; data_out, out_src, contended SHALL hold.
REQ-021 On load=0 (out_valid=1, out_ready=0): all outputs and arbitration state SHALL hold; requesters keep req and data stable until granted.
REQ-022 Full throughput: with out_ready held 1 and req nonzero, one grant per cycle.
REQ-023 Pointer update on grant: if lock[winner]=1 and burst_cnt<MAX_BURST-1, rr_ptr<=winner and burst_cnt<=burst_cnt+1; otherwise rr_ptr<=(winner+1) mod N_INPUTS and burst_cnt<=0.
REQ-024 If the locked channel drops req, the search from rr_ptr SHALL skip it normally and burst_cnt SHALL reset to 0 on the next grant to any other channel.
REQ-025 MAX_BURST=1 SHALL make lock ineffective (pure round-robin).
REQ-026 No grant cycle SHALL leave rr_ptr and burst_cnt unchanged.
REQ-027 Wrap: winner=N_INPUTS-1 unlocked SHALL set rr_ptr to 0 (non-power-of-two N_INPUTS included).

Reset
REQ-028 While rst=1 at a clock edge: out_valid<=0, data_out<=0, out_src<=0, contended<=0, rr_ptr<=0, burst_cnt<=0; grant SHALL be forced to 0 during rst.
REQ-029 Reset asserted mid-burst or with out_valid=1 and out_ready=0 SHALL discard the held payload and lock state; first grant after release searches from channel 0.

Verification (N_INPUTS=4, DATA_WIDTH=8, MAX_BURST=3)
REQ-030 All four req=1, lock=0, out_ready=1, data_in[k]=0x10+k -> grants 0,1,2,3,0 on successive cycles; data_out 0x10,0x11,0x12,0x13 one cycle later; contended=1.
REQ-031 req=0b0100 only -> grant=0b0100, next cycle out_valid=1, data_out=0x12, out_src=2, contended=0; then req=0 -> out_valid falls next cycle.
REQ-032 out_valid=1, out_ready=0 for 3 cycles with req=0b1111 -> grant=0 and data_out stable those cycles; out_ready=1 -> next grant proceeds from saved rr_ptr.
REQ-033 req=0b0011, lock=0b0001 -> grants 0,0,0,1,0,0,0,1 (burst capped at 3).
REQ-034 Locked channel 0 granted twice, then req[0] drops -> next grant channel 1, burst_cnt=0.
REQ-035 rst pulsed for 1 cycle while out_valid=1, out_ready=0, rr_ptr=2 -> next cycle out_valid=0, data_out=0; with req=0b1111 first grant=0b0001.
